dmac_engine: RTL and testbench
==============================

// Module: dmac_engine
// PURPOSE
//  Sequencing engine for the single-channel DMA. Consumes src/dst/len and the
//  one-cycle start pulse from the APB config block and moves data through
//  a one-word buffer. Reads use an AXI4-Lite-style AR/R master port and
//  writes use an AW/W/B master port. Reports completion on done_o, which
//  feeds back to the config block's status register.
// PARAMETERS
//  ADDR_W   32   address width of src/dst and AR/AW channels
//  LEN_W    16   width of byte length
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       asynchronous active-low reset
//  src_addr_i  in   ADDR_W  source start address (sampled on accepted start)
//  dst_addr_i  in   ADDR_W  destination start address (sampled on accepted start)
//  byte_len_i  in   LEN_W   transfer length in bytes (sampled on accepted start)
//  start_i     in   1       one-cycle start pulse
//  done_o      out  1       1 = idle/complete, 0 = transfer in progress
//  araddr_o    out  ADDR_W  read address
//  arvalid_o   out  1       read address valid
//  arready_i   in   1       read address accepted
//  rdata_i     in   32      read data
//  rvalid_i    in   1       read data valid
//  rready_o    out  1       read data ready
//  awaddr_o    out  ADDR_W  write address
//  awvalid_o   out  1       write address valid
//  awready_i   in   1       write address accepted
//  wdata_o     out  32      write data (buffered read word)
//  wvalid_o    out  1       write data valid
//  wready_i    in   1       write data accepted
//  bvalid_i    in   1       write response valid
//  bready_o    out  1       write response ready
// BEHAVIOUR
//  - One clock domain. rst_n asserted asynchronously forces state IDLE and
//    clears all internal regs and valids/readies to 0. done_o resets to 1.
//    Reset mid-transfer abandons outstanding beats; no recovery is attempted.
//  - FSM states: IDLE, RREQ, RDATA, WREQ, WRESP.
//  - IDLE: done_o=1, all valids/readies 0. On start_i, latch src, dst and
//    cnt = {byte_len_i[LEN_W-1:2],2'b00}. Low 2 len bits are ignored and
//    the length rounds down to whole 4-byte words.
//    If the latched cnt==0: stay IDLE and keep done_o at 1.
//    Otherwise go to RREQ; done_o falls in the cycle after start_i.
//  - start_i outside IDLE is ignored. Config inputs are don't-care after latch.
//  - RREQ: arvalid_o=1, araddr_o=src. Both stay stable until arready_i.
//    On arready_i go to RDATA.
//  - RDATA: rready_o=1. On rvalid_i, capture rdata_i into buf and go to WREQ.
//    rresp is not checked.
//  - WREQ: on entry, awvalid_o and wvalid_o are asserted together.
//    awaddr_o=dst and wdata_o=buf. Each valid drops in the cycle after its
//    own ready is seen; AW and W may be accepted in any order or together.
//    When both are accepted go to WRESP. Minimum WREQ time is 1 cycle.
//  - WRESP: bready_o=1. On bvalid_i: src+=4, dst+=4, cnt-=4.
//    If the new cnt==0 go to IDLE (done_o=1 next cycle); else go to RREQ.
//    bresp is not checked.
//  - Address increments wrap modulo 2^ADDR_W. No 4KB boundary handling.
//  - Only one outstanding beat at a time. Minimum 4 cycles per word at zero
//    wait states: RREQ, RDATA, WREQ, WRESP.
//  - All outputs are register-driven or decoded from state only. They have
//    no combinational path from *ready_i or *valid_i.
// TESTING
//  1 Reset: hold rst_n=0 mid-RDATA, release -> done_o=1, all valids 0, IDLE.
//  2 Basic: src=0x1000, dst=0x2000, len=16, zero-wait slave -> 4 AR at
//    0x1000..0x100C, 4 AW at 0x2000..0x200C, data copied, done_o rises
//    16 cycles after start.
//  3 Zero/odd len: len=0 -> no bus activity, done_o stays 1.
//    len=7 -> exactly 1 word moved.
//  4 Backpressure: random stalls on arready/rvalid/awready/wready/bvalid.
//    Include AW before W, W before AW, and both together. Check araddr/awaddr
//    and wdata stay stable while valid is high, and each valid drops only
//    after its handshake.
//  5 Start while busy: second start_i with new cfg mid-transfer -> ignored,
//    original 8-byte transfer completes unchanged.
//  6 Wrap: src=0xFFFF_FFFC, len=8 -> AR addresses 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/dmac_engine.sv
// Single-channel DMA sequencing engine: copies byte_len/4 words from src to dst,
// one outstanding beat at a time, through an AR/R read port and an AW/W/B write port.
module dmac_engine #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] src_addr_i,
   input  logic [ADDR_W-1:0] dst_addr_i,
   input  logic [LEN_W-1:0]  byte_len_i,
   input  logic              start_i,
   output logic              done_o,
   output logic [ADDR_W-1:0] araddr_o,
   output logic              arvalid_o,
   input  logic              arready_i,
   input  logic [31:0]       rdata_i,
   input  logic              rvalid_i,
   output logic              rready_o,
   output logic [ADDR_W-1:0] awaddr_o,
   output logic              awvalid_o,
   input  logic              awready_i,
   output logic [31:0]       wdata_o,
   output logic              wvalid_o,
   input  logic              wready_i,
   input  logic              bvalid_i,
   output logic              bready_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RREQ,
      S_RDATA,
      S_WREQ,
      S_WRESP
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [LEN_W-1:0]  r_cnt;
   logic [31:0]       r_buf;
   logic              r_awvalid;
   logic              r_wvalid;
   logic [LEN_W-1:0]  w_start_cnt;
   logic              w_aw_done;
   logic              w_w_done;
   logic              w_unused_len;

   // Length rounds down to whole words; the low two bits never matter.
   assign w_start_cnt  = {byte_len_i[LEN_W-1:2], 2'b00};
   assign w_unused_len = ^byte_len_i[1:0];

   // A write channel counts as accepted once its valid has dropped or its ready is seen now.
   assign w_aw_done = !r_awvalid || awready_i;
   assign w_w_done  = !r_wvalid  || wready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start_i && (w_start_cnt != '0)) w_next = S_RREQ;
         S_RREQ:  if (arready_i) w_next = S_RDATA;
         S_RDATA: if (rvalid_i) w_next = S_WREQ;
         S_WREQ:  if (w_aw_done && w_w_done) w_next = S_WRESP;
         S_WRESP: if (bvalid_i) w_next = (r_cnt == LEN_W'(4)) ? S_IDLE : S_RREQ;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src     <= '0;
         r_dst     <= '0;
         r_cnt     <= '0;
         r_buf     <= '0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_src <= src_addr_i;
                  r_dst <= dst_addr_i;
                  r_cnt <= w_start_cnt;
               end
            end
            S_RDATA: begin
               if (rvalid_i) begin
                  r_buf     <= rdata_i;
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
               end
            end
            S_WREQ: begin
               if (awready_i) r_awvalid <= 1'b0;
               if (wready_i)  r_wvalid  <= 1'b0;
            end
            S_WRESP: begin
               if (bvalid_i) begin
                  r_src <= r_src + ADDR_W'(4);
                  r_dst <= r_dst + ADDR_W'(4);
                  r_cnt <= r_cnt - LEN_W'(4);
               end
            end
            default: ;
         endcase
      end
   end

   assign done_o    = (r_state == S_IDLE);
   assign arvalid_o = (r_state == S_RREQ);
   assign rready_o  = (r_state == S_RDATA);
   assign bready_o  = (r_state == S_WRESP);
   assign awvalid_o = r_awvalid;
   assign wvalid_o  = r_wvalid;
   assign araddr_o  = r_src;
   assign awaddr_o  = r_dst;
   assign wdata_o   = r_buf;

endmodule

// File: tb/tb_dmac_engine.sv
// Randomized bench for dmac_engine: a stalling bus slave logs every handshake and a
// word-level copy model supplies the expected address and data sequences.
module tb_dmac_engine;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LEN_W  = 16;
   localparam int unsigned TMO    = 4000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] src_addr_i;
   logic [ADDR_W-1:0] dst_addr_i;
   logic [LEN_W-1:0]  byte_len_i;
   logic              start_i;
   logic              done_o;
   logic [ADDR_W-1:0] araddr_o;
   logic              arvalid_o;
   logic              arready_i;
   logic [31:0]       rdata_i;
   logic              rvalid_i;
   logic              rready_o;
   logic [ADDR_W-1:0] awaddr_o;
   logic              awvalid_o;
   logic              awready_i;
   logic [31:0]       wdata_o;
   logic              wvalid_o;
   logic              wready_i;
   logic              bvalid_i;
   logic              bready_o;

   dmac_engine #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .byte_len_i(byte_len_i),
      .start_i(start_i), .done_o(done_o),
      .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
      .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
      .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
      .wdata_o(wdata_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
      .bvalid_i(bvalid_i), .bready_o(bready_o)
   );

   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Slave behaviour knobs and handshake logs
   int unsigned stall_pct = 0;
   int unsigned wmode     = 0;
   bit          hold_r    = 1'b0;
   logic [31:0] ar_log[$];
   logic [31:0] aw_log[$];
   logic [31:0] w_log[$];
   int unsigned n_b = 0;

   bit          rd_pend;
   logic [31:0] rd_word;
   logic        p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br;
   logic [31:0] p_araddr, p_awaddr, p_wdata;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5EED_1234;
   endfunction

   function automatic bit coin();
      return $urandom_range(99) >= stall_pct;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rd_pend = 1'b0;
            {p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br} = '0;
            p_araddr = '0; p_awaddr = '0; p_wdata = '0;
            arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
            awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
         end else begin
            // Handshakes that completed on the rising edge just passed
            if (p_arv && p_arr) begin
               ar_log.push_back(p_araddr);
               rd_pend = 1'b1;
               rd_word = mem_word(p_araddr);
               check("arvalid_drop", arvalid_o, 0);
            end else if (p_arv) begin
               check("arvalid_hold", arvalid_o, 1);
               check("araddr_stable", araddr_o, p_araddr);
            end
            if (p_rv && p_rr) rd_pend = 1'b0;
            if (p_awv && p_awr) begin
               aw_log.push_back(p_awaddr);
               check("awvalid_drop", awvalid_o, 0);
            end else if (p_awv) begin
               check("awvalid_hold", awvalid_o, 1);
               check("awaddr_stable", awaddr_o, p_awaddr);
            end
            if (p_wv && p_wr) begin
               w_log.push_back(p_wdata);
               check("wvalid_drop", wvalid_o, 0);
            end else if (p_wv) begin
               check("wvalid_hold", wvalid_o, 1);
               check("wdata_stable", wdata_o, p_wdata);
            end
            if (p_bv && p_br) n_b++;

            arready_i = coin();
            rvalid_i  = rd_pend && !hold_r && coin();
            rdata_i   = rd_pend ? rd_word : $urandom();
            bvalid_i  = (aw_log.size() > n_b) && (w_log.size() > n_b) && coin();
            case (wmode)
               1: begin
                  awready_i = coin();
                  wready_i  = (aw_log.size() > w_log.size()) && coin();
               end
               2: begin
                  wready_i  = coin();
                  awready_i = (w_log.size() > aw_log.size()) && coin();
               end
               3: begin
                  awready_i = coin();
                  wready_i  = awready_i;
               end
               default: begin
                  awready_i = coin();
                  wready_i  = coin();
               end
            endcase

            p_arv = arvalid_o; p_arr = arready_i; p_araddr = araddr_o;
            p_rv  = rvalid_i;  p_rr  = rready_o;
            p_awv = awvalid_o; p_awr = awready_i; p_awaddr = awaddr_o;
            p_wv  = wvalid_o;  p_wr  = wready_i;  p_wdata  = wdata_o;
            p_bv  = bvalid_i;  p_br  = bready_o;
         end
      end
   end

   // Launches one transfer and compares the logged bus traffic with the word-copy model.
   task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] len, input bit poke, input bit chk_lat);
      int unsigned nw;
      int unsigned k;
      logic [31:0] a;
      nw = int'(len) / 4;
      ar_log.delete(); aw_log.delete(); w_log.delete(); n_b = 0;
      @(negedge clk);
      src_addr_i = src; dst_addr_i = dst; byte_len_i = len; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      src_addr_i = $urandom(); dst_addr_i = $urandom(); byte_len_i = 16'($urandom());
      k = 0;
      check("done_after_start", done_o, (nw == 0) ? 1 : 0);
      if (nw == 0) begin
         repeat (6) @(negedge clk);
         check("done_len0_hold", done_o, 1);
      end else begin
         while (!done_o && k < TMO) begin
            start_i = poke && (k == 2);
            if (start_i) byte_len_i = 16'h0040;
            @(negedge clk);
            k++;
         end
         start_i = 1'b0;
         check("done_timeout", (k < TMO) ? 1 : 0, 1);
         if (chk_lat) check("done_latency", k, 4 * nw);
      end
      @(negedge clk);
      #1;
      check("ar_count", ar_log.size(), nw);
      check("aw_count", aw_log.size(), nw);
      check("w_count", w_log.size(), nw);
      check("b_count", n_b, nw);
      for (int unsigned i = 0; i < nw; i++) begin
         a = src + 32'(4 * i);
         if (i < ar_log.size()) check("araddr", ar_log[i], a);
         if (i < w_log.size())  check("wdata", w_log[i], mem_word(a));
         a = dst + 32'(4 * i);
         if (i < aw_log.size()) check("awaddr", aw_log[i], a);
      end
   endtask

   initial begin
      int unsigned k;
      rst_n = 1'b0; start_i = 1'b0;
      src_addr_i = '0; dst_addr_i = '0; byte_len_i = '0;
      repeat (3) @(negedge clk);
      check("rst_done", done_o, 1);
      check("rst_valids", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}, 0);
      rst_n = 1'b1;

      stall_pct = 0; wmode = 0;
      run_xfer(32'h0000_1000, 32'h0000_2000, 16'd16, 1'b0, 1'b1);
      run_xfer(32'h0000_3000, 32'h0000_4000, 16'd0, 1'b0, 1'b0);
      run_xfer(32'h0000_3000, 32'h0000_4000, 16'd7, 1'b0, 1'b1);
      run_xfer(32'h0000_5000, 32'h0000_6000, 16'd8, 1'b1, 1'b1);
      run_xfer(32'hFFFF_FFFC, 32'hFFFF_FFF8, 16'd8, 1'b0, 1'b1);

      for (int unsigned it = 0; it < 16; it++) begin
         stall_pct = $urandom_range(60);
         wmode     = it % 4;
         run_xfer($urandom(), $urandom(), 16'($urandom_range(40)), 1'b0, 1'b0);
      end

      // Reset while parked in the read-data phase
      stall_pct = 0; wmode = 0; hold_r = 1'b1;
      ar_log.delete(); aw_log.delete(); w_log.delete(); n_b = 0;
      @(negedge clk);
      src_addr_i = 32'h0000_7000; dst_addr_i = 32'h0000_8000; byte_len_i = 16'd16; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      k = 0;
      while (!rready_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("reach_rdata", rready_o, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_done", done_o, 1);
      check("async_rst_valids", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}, 0);
      repeat (2) @(negedge clk);
      hold_r = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_done", done_o, 1);
      check("post_rst_valids", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}, 0);
      run_xfer(32'h0000_9000, 32'h0000_A000, 16'd12, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
